// File: rtl/alu_sequencer.sv
// alu_sequencer: 4x64 register file feeding an external ALU.
// ADD/SUB/COMPARE take three edges from accept to writeback (IDLE->EXEC->WAIT).
// LOADI writes the register file directly and stays in IDLE.
module alu_sequencer (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [1:0]         instr_op,
  input  logic [1:0]         instr_dst,
  input  logic [1:0]         instr_src0,
  input  logic [1:0]         instr_src1,
  input  logic signed [63:0] instr_imm,
  output logic               alu_enable,
  output logic [1:0]         alu_opcode,
  output logic signed [63:0] alu_in0,
  output logic signed [63:0] alu_in1,
  input  logic signed [64:0] alu_out,
  output logic               wb_valid,
  output logic [1:0]         wb_dst,
  output logic [63:0]        wb_data,
  output logic               ovf,
  output logic               gt,
  output logic               eq,
  output logic               lt,
  input  logic [1:0]         rd_addr,
  output logic [63:0]        rd_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_CMP   = 2'd2;
  localparam logic [1:0] OP_LOADI = 2'd3;

  logic [1:0]       state;
  logic [3:0][63:0] regs;
  logic [1:0]       dst_q;
  logic [1:0]       op_q;

  logic [1:0]  cmp_code;
  logic [63:0] res_data;
  logic        res_ovf;

  assign instr_ready = (state == IDLE) & ~rst;
  assign rd_data     = regs[rd_addr];
  assign cmp_code    = alu_out[1:0];

  // Shape the sampled ALU result into writeback data and overflow
  always_comb begin
    res_data = alu_out[63:0];
    res_ovf  = alu_out[64] ^ alu_out[63];
    if (op_q == OP_CMP) begin
      res_data = {62'd0, cmp_code};
      res_ovf  = 1'b0;
    end
  end

  // Sequencer state, register file, ALU drive and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      regs       <= '0;
      dst_q      <= '0;
      op_q       <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_in0    <= '0;
      alu_in1    <= '0;
      wb_valid   <= 1'b0;
      wb_dst     <= '0;
      wb_data    <= '0;
      ovf        <= 1'b0;
      gt         <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (instr_op == OP_LOADI) begin
              regs[instr_dst] <= instr_imm;
              wb_valid        <= 1'b1;
              wb_dst          <= instr_dst;
              wb_data         <= instr_imm;
              ovf             <= 1'b0;
            end else begin
              // Operands captured now, so dst==src and src0==src1 are safe
              alu_in0    <= regs[instr_src0];
              alu_in1    <= regs[instr_src1];
              alu_opcode <= instr_op;
              alu_enable <= 1'b1;
              dst_q      <= instr_dst;
              op_q       <= instr_op;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          alu_enable <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          regs[dst_q] <= res_data;
          wb_valid    <= 1'b1;
          wb_dst      <= dst_q;
          wb_data     <= res_data;
          ovf         <= res_ovf;
          if (op_q == OP_CMP) begin
            gt <= (cmp_code == 2'd1);
            eq <= (cmp_code == 2'd0);
            lt <= (cmp_code == 2'd2);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
